// File: rtl/fp_mult_host_if_if.sv
// Bus bundle for fp_mult_host_if.
// Groups the host-side operand/result handshakes and the byte-serial
// fp_mult core connection so the sequencer sees them as one port.
//   IN_VALID/IN_READY/OP_A/OP_B      : operand pair handshake (into sequencer)
//   OUT_VALID/OUT_READY/RESULT/ERR   : product handshake (out of sequencer)
//   MULT_RESET/MULT_ENABLE/MULT_DATA : drive to the core
//   MULT_DATA_OUT/MULT_READY         : response from the core
// slave  : the sequencer's view.
// master : the surrounding environment (host plus core).
interface fp_mult_host_if_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [63:0] OP_A;
  logic [63:0] OP_B;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [63:0] RESULT;
  logic        ERR;
  logic        MULT_RESET;
  logic        MULT_ENABLE;
  logic [7:0]  MULT_DATA;
  logic [7:0]  MULT_DATA_OUT;
  logic        MULT_READY;

  modport master (
    output IN_VALID, OP_A, OP_B, OUT_READY, MULT_DATA_OUT, MULT_READY,
    input  IN_READY, OUT_VALID, RESULT, ERR, MULT_RESET, MULT_ENABLE, MULT_DATA
  );

  modport slave (
    input  IN_VALID, OP_A, OP_B, OUT_READY, MULT_DATA_OUT, MULT_READY,
    output IN_READY, OUT_VALID, RESULT, ERR, MULT_RESET, MULT_ENABLE, MULT_DATA
  );
endinterface

// File: rtl/fp_mult_host_if.sv
// Host-side sequencer for the byte-serial fp_mult core.
// Accepts a pair of IEEE-754 doubles, pulses the core reset for one cycle,
// streams the 16 operand bytes (A then B, MSB first), waits for the core to
// answer, reassembles its 8 result bytes (first byte in [63:56]) and presents
// the product on an output handshake.  A watchdog substitutes a quiet NaN
// with ERR=1 if the core never answers or its burst ends early.
// Ports:
//   CLK     : rising-edge clock
//   RESET_N : asynchronous active-low reset (holds the core in reset too)
//   bus     : fp_mult_host_if_if.slave -- operand/result handshakes and core link
// Parameter:
//   TIMEOUT_CYCLES : cycles allowed in WAIT before giving up (1..255)
module fp_mult_host_if #(
  parameter int unsigned TIMEOUT_CYCLES = 31
) (
  input logic              CLK,
  input logic              RESET_N,
  fp_mult_host_if_if.slave bus
);

  localparam logic [63:0] QNAN        = 64'h7FF8_0000_0000_0000;
  localparam logic [7:0]  TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_WAIT,
    S_COLLECT,
    S_HOLD
  } state_t;

  state_t       state;
  logic [127:0] feed_sr;   // {A, B}; top byte is the next one to send
  logic [3:0]   byte_cnt;  // bytes sent in FEED / bytes collected in COLLECT
  logic [7:0]   wait_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state           <= S_IDLE;
      feed_sr         <= '0;
      byte_cnt        <= '0;
      wait_cnt        <= '0;
      bus.IN_READY    <= 1'b0;
      bus.OUT_VALID   <= 1'b0;
      bus.RESULT      <= '0;
      bus.ERR         <= 1'b0;
      bus.MULT_RESET  <= 1'b1;
      bus.MULT_ENABLE <= 1'b0;
      bus.MULT_DATA   <= '0;
    end else begin
      case (state)
        // Wait for an operand pair; IN_READY is only ever high here.
        S_IDLE: begin
          bus.MULT_RESET <= 1'b0;
          bus.IN_READY   <= 1'b1;
          if (bus.IN_VALID && bus.IN_READY) begin
            feed_sr        <= {bus.OP_A, bus.OP_B};
            bus.ERR        <= 1'b0;
            bus.IN_READY   <= 1'b0;
            bus.MULT_RESET <= 1'b1;
            state          <= S_CLR;
          end
        end

        // One-cycle core clear; the first operand byte goes out as it ends.
        S_CLR: begin
          bus.MULT_RESET  <= 1'b0;
          bus.MULT_ENABLE <= 1'b1;
          bus.MULT_DATA   <= feed_sr[127:120];
          feed_sr         <= {feed_sr[119:0], 8'h00};
          byte_cnt        <= 4'd0;
          state           <= S_FEED;
        end

        // byte_cnt is the index of the byte currently on MULT_DATA.
        S_FEED: begin
          if (byte_cnt == 4'd15) begin
            bus.MULT_ENABLE <= 1'b0;
            bus.MULT_DATA   <= '0;
            wait_cnt        <= '0;
            state           <= S_WAIT;
          end else begin
            bus.MULT_DATA <= feed_sr[127:120];
            feed_sr       <= {feed_sr[119:0], 8'h00};
            byte_cnt      <= byte_cnt + 4'd1;
          end
        end

        // The cycle READY is first seen already carries result byte 0.
        S_WAIT: begin
          if (bus.MULT_READY) begin
            bus.RESULT <= {bus.RESULT[55:0], bus.MULT_DATA_OUT};
            byte_cnt   <= 4'd1;
            state      <= S_COLLECT;
          end else if (wait_cnt == TIMEOUT_LIM) begin
            bus.RESULT    <= QNAN;
            bus.ERR       <= 1'b1;
            bus.OUT_VALID <= 1'b1;
            state         <= S_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        // READY must stay high for the whole burst; a gap means a short burst.
        S_COLLECT: begin
          if (bus.MULT_READY) begin
            bus.RESULT <= {bus.RESULT[55:0], bus.MULT_DATA_OUT};
            if (byte_cnt == 4'd7) begin
              bus.ERR       <= 1'b0;
              bus.OUT_VALID <= 1'b1;
              state         <= S_HOLD;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end else begin
            bus.RESULT    <= QNAN;
            bus.ERR       <= 1'b1;
            bus.OUT_VALID <= 1'b1;
            state         <= S_HOLD;
          end
        end

        // Result held until taken; IN_READY returns the cycle after.
        S_HOLD: begin
          if (bus.OUT_VALID && bus.OUT_READY) begin
            bus.OUT_VALID <= 1'b0;
            bus.IN_READY  <= 1'b1;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
